// File: rtl/bram_port_arbiter_if.sv
// Requester-side request/response channel for one port of bram_port_arbiter.
// The requester drives through master; the arbiter answers through slave.
interface bram_port_arbiter_if #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 6
) ();
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] wdata;
  logic                  rsp_valid;
  logic [data_width-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous write-first BRAM port between a CPU requester (req0) and a
// DMA/video requester (req1), with round-robin or fixed priority plus a starvation guard.
module bram_port_arbiter #(
  parameter int unsigned data_width     = 8,
  parameter int unsigned addr_width     = 6,
  parameter int unsigned fixed_priority = 0,
  parameter int unsigned max_wait       = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_port_arbiter_if.slave    req0,
  bram_port_arbiter_if.slave    req1,
  output logic                  bram_clken,
  output logic                  bram_we,
  output logic [addr_width-1:0] bram_addr,
  output logic [data_width-1:0] bram_din,
  input  logic [data_width-1:0] bram_dout
);

  localparam int unsigned WaitWidth = (max_wait < 1) ? 1 : $clog2(max_wait + 1);

  logic                 last_grant_q;
  logic [WaitWidth-1:0] wait_cnt_q;
  logic                 rsp_pend_q;
  logic                 rsp_sel_q;
  logic                 grant0;
  logic                 grant1;

  // Grants already include valid, so grantN doubles as reqN_ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0.valid && !req1.valid) begin
        grant0 = 1'b1;
      end else if (req1.valid && !req0.valid) begin
        grant1 = 1'b1;
      end else if (req0.valid && req1.valid) begin
        if (fixed_priority == 0) begin
          grant0 = last_grant_q;
          grant1 = ~last_grant_q;
        end else if (wait_cnt_q == WaitWidth'(max_wait)) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end
    end
  end

  assign req0.ready = grant0;
  assign req1.ready = grant1;

  assign bram_clken = grant0 | grant1;
  assign bram_we    = grant1 ? req1.we : (grant0 & req0.we);
  assign bram_addr  = grant1 ? req1.addr : req0.addr;
  assign bram_din   = grant1 ? req1.wdata : req0.wdata;

  // Reset also masks a response already in flight.
  assign req0.rsp_valid = rsp_pend_q & ~rsp_sel_q & ~reset;
  assign req1.rsp_valid = rsp_pend_q & rsp_sel_q & ~reset;
  assign req0.rsp_rdata = bram_dout;
  assign req1.rsp_rdata = bram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_sel_q    <= 1'b0;
    end else begin
      rsp_pend_q <= bram_clken;
      if (bram_clken) begin
        rsp_sel_q    <= grant1;
        last_grant_q <= grant1;
      end
      if (fixed_priority == 0) begin
        wait_cnt_q <= '0;
      end else if (req1.valid && !grant1) begin
        if (wait_cnt_q != WaitWidth'(max_wait)) begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench: a round-robin instance and a fixed-priority (max_wait=3) instance share one
// stimulus stream; each has its own BRAM model and reference memory.
module tb_bram_port_arbiter;

  localparam int unsigned Mw = 3;

  logic clk;
  logic reset;
  logic load;

  logic       v0, v1, we0, we1;
  logic [5:0] a0, a1;
  logic [7:0] d0, d1;

  bram_port_arbiter_if #(.data_width(8), .addr_width(6)) rr_p0 ();
  bram_port_arbiter_if #(.data_width(8), .addr_width(6)) rr_p1 ();
  bram_port_arbiter_if #(.data_width(8), .addr_width(6)) fx_p0 ();
  bram_port_arbiter_if #(.data_width(8), .addr_width(6)) fx_p1 ();

  assign rr_p0.valid = v0;  assign rr_p0.we = we0;  assign rr_p0.addr = a0;  assign rr_p0.wdata = d0;
  assign rr_p1.valid = v1;  assign rr_p1.we = we1;  assign rr_p1.addr = a1;  assign rr_p1.wdata = d1;
  assign fx_p0.valid = v0;  assign fx_p0.we = we0;  assign fx_p0.addr = a0;  assign fx_p0.wdata = d0;
  assign fx_p1.valid = v1;  assign fx_p1.we = we1;  assign fx_p1.addr = a1;  assign fx_p1.wdata = d1;

  logic [1:0] ck, bw;
  logic [5:0] ba   [2];
  logic [7:0] bd   [2];
  logic [7:0] dout [2];
  logic [7:0] bram_mem [2][64];

  bram_port_arbiter #(
    .data_width(8), .addr_width(6), .fixed_priority(0), .max_wait(15)
  ) u_rr (
    .clk(clk), .reset(reset), .req0(rr_p0), .req1(rr_p1),
    .bram_clken(ck[0]), .bram_we(bw[0]), .bram_addr(ba[0]), .bram_din(bd[0]),
    .bram_dout(dout[0])
  );

  bram_port_arbiter #(
    .data_width(8), .addr_width(6), .fixed_priority(1), .max_wait(Mw)
  ) u_fx (
    .clk(clk), .reset(reset), .req0(fx_p0), .req1(fx_p1),
    .bram_clken(ck[1]), .bram_we(bw[1]), .bram_addr(ba[1]), .bram_din(bd[1]),
    .bram_dout(dout[1])
  );

  logic [1:0] rdy0, rdy1, rv0, rv1;
  logic [7:0] rd [2];
  assign rdy0[0] = rr_p0.ready;     assign rdy0[1] = fx_p0.ready;
  assign rdy1[0] = rr_p1.ready;     assign rdy1[1] = fx_p1.ready;
  assign rv0[0]  = rr_p0.rsp_valid; assign rv0[1]  = fx_p0.rsp_valid;
  assign rv1[0]  = rr_p1.rsp_valid; assign rv1[1]  = fx_p1.rsp_valid;
  assign rd[0]   = rr_p0.rsp_rdata; assign rd[1]   = fx_p0.rsp_rdata;

  // Synchronous write-first BRAM with clock enable.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (load) begin
        for (int i = 0; i < 64; i++) bram_mem[m][i] <= 8'(i * 13 + 7);
      end else if (ck[m]) begin
        if (bw[m]) begin
          bram_mem[m][ba[m]] <= bd[m];
          dout[m]            <= bd[m];
        end else begin
          dout[m] <= bram_mem[m][ba[m]];
        end
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] ref_mem [2][64];
  logic       pref      [2];  // port that wins the next round-robin conflict
  int         denied    [2];  // consecutive cycles port 1 waited (fixed mode)
  logic       pend      [2];
  logic       pend_port [2];
  logic [7:0] pend_data [2];
  int         starve    [2];

  int n_checks;
  int n_errors;
  int cyc;

  task automatic check(input string name, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s dut=%0d cycle=%0d actual=%0h required=%0h", name, m, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_cycle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      logic       g0, g1, w;
      logic [5:0] ad;
      logic [7:0] wd;
      check("rsp0_valid", m, 32'(rv0[m]), 32'(pend[m] && !pend_port[m] && !reset));
      check("rsp1_valid", m, 32'(rv1[m]), 32'(pend[m] && pend_port[m] && !reset));
      if (pend[m] && !reset) check("rsp_rdata", m, 32'(rd[m]), 32'(pend_data[m]));

      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset) begin
        if (v0 && v1) begin
          if (m == 0) g1 = pref[m];
          else        g1 = (denied[m] >= int'(Mw));
          g0 = ~g1;
        end else begin
          g0 = v0;
          g1 = v1;
        end
      end
      w  = g1 ? we1 : (g0 & we0);
      ad = g1 ? a1 : a0;
      wd = g1 ? d1 : d0;

      check("ready0", m, 32'(rdy0[m]), 32'(g0));
      check("ready1", m, 32'(rdy1[m]), 32'(g1));
      check("clken", m, 32'(ck[m]), 32'(g0 | g1));
      check("bram_we", m, 32'(bw[m]), 32'(w));
      if (g0 | g1) check("bram_addr", m, 32'(ba[m]), 32'(ad));
      check("one_ready", m, 32'(rdy0[m] & rdy1[m]), 32'd0);

      if (v1 && !reset && rdy1[m] !== 1'b1) starve[m]++;
      else                                  starve[m] = 0;
      check("starve", m, 32'(starve[m] > ((m == 0) ? 1 : int'(Mw))), 32'd0);

      pend[m]      = g0 | g1;
      pend_port[m] = g1;
      if (g0 | g1) begin
        if (w) begin
          ref_mem[m][ad] = wd;
          pend_data[m]   = wd;
        end else begin
          pend_data[m] = ref_mem[m][ad];
        end
        pref[m] = g0;
      end
      if (v1 && !g1) denied[m]++;
      else           denied[m] = 0;
      if (reset) begin
        pref[m]   = 1'b0;
        denied[m] = 0;
      end
    end
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_cycle();
      check("rst_ready", 0, 32'({rdy0, rdy1}), 32'd0);
      check("rst_clken", 0, 32'(ck), 32'd0);
      tick();
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v0, v1;
    logic [1:0] exp_r0;  // bit m: expected ready0 for DUT m
    logic [1:0] exp_r1;
  } vec_t;

  vec_t tbl [8];
  logic hold0, hold1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) ref_mem[m][i] = 8'(i * 13 + 7);
      pref[m] = 0; denied[m] = 0; pend[m] = 0; pend_port[m] = 0; pend_data[m] = 0;
      starve[m] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[i].v0     = 1'b1;
      tbl[i].v1     = 1'b1;
      tbl[i].exp_r0 = {1'(i % 4 != 3), 1'(i % 2 == 0)};
      tbl[i].exp_r1 = {1'(i % 4 == 3), 1'(i % 2 == 1)};
    end

    load = 1'b1;
    do_reset(1);
    load = 1'b0;
    do_reset(2);

    // Idle after reset.
    model_cycle();
    check("post_rst_rsp", 0, 32'({rv0, rv1}), 32'd0);
    check("post_rst_we", 0, 32'(bw), 32'd0);
    tick();

    // Single read from port 0.
    v0 = 1; we0 = 0; a0 = 6'h05;
    model_cycle();
    check("t1_ready0", 0, 32'(rdy0), 32'b11);
    check("t1_clken", 0, 32'(ck), 32'b11);
    tick();
    idle();
    model_cycle();
    check("t1_rsp0", 0, 32'(rv0), 32'b11);
    check("t1_rsp1", 0, 32'(rv1), 32'b00);
    check("t1_rdata", 0, 32'(rd[0]), 32'h48);
    tick();

    // Write then immediate read of the same address.
    v0 = 1; we0 = 1; a0 = 6'h10; d0 = 8'hA5;
    model_cycle();
    check("t2_wr_ready", 0, 32'(rdy0), 32'b11);
    tick();
    we0 = 0; d0 = 8'h00;
    model_cycle();
    check("t2_rd_ready", 0, 32'(rdy0), 32'b11);
    check("t2_wr_rsp", 0, 32'(rd[0]), 32'hA5);
    tick();
    idle();
    model_cycle();
    check("t2_rd_rsp", 1, 32'(rd[1]), 32'hA5);
    check("t2_rd_valid", 0, 32'(rv0), 32'b11);
    tick();

    // Continuous conflict: round-robin alternates, fixed grants port 1 every 4th.
    do_reset(1);
    we0 = 0; a0 = 6'h08; we1 = 1; a1 = 6'h21; d1 = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      v0 = tbl[i].v0;
      v1 = tbl[i].v1;
      model_cycle();
      check("tbl_ready0", i, 32'(rdy0), 32'(tbl[i].exp_r0));
      check("tbl_ready1", i, 32'(rdy1), 32'(tbl[i].exp_r1));
      tick();
    end
    idle();
    model_cycle();
    tick();

    // Reset while a port-1 read response is in flight.
    v1 = 1; we1 = 0; a1 = 6'h07;
    model_cycle();
    check("t5_accept", 0, 32'(rdy1), 32'b11);
    tick();
    reset = 1'b1;
    model_cycle();
    check("t5_rsp_in_rst", 0, 32'(rv1), 32'b00);
    tick();
    reset = 1'b0;
    idle();
    model_cycle();
    check("t5_rsp_after", 0, 32'(rv1), 32'b00);
    tick();
    v0 = 1; v1 = 1; a0 = 6'h01; a1 = 6'h02;
    model_cycle();
    check("t5_conflict", 0, 32'(rdy0), 32'b11);
    tick();
    idle();

    // Random traffic with requester hold rules.
    hold0 = 0;
    hold1 = 0;
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if (!hold0) begin
        we0 = 1'($urandom_range(0, 1)); a0 = 6'($urandom_range(0, 15)); d0 = 8'($urandom);
      end
      if (!hold1) begin
        we1 = 1'($urandom_range(0, 1)); a1 = 6'($urandom_range(0, 15)); d1 = 8'($urandom);
      end
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      model_cycle();
      hold0 = v0 && !(rdy0 == 2'b11);
      hold1 = v1 && !(rdy1 == 2'b11);
      tick();
    end
    reset = 1'b0;
    idle();
    model_cycle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
